// File: rtl/core_to_wb_master_if.sv
// Core data port plus Wishbone classic master signals bundled for core_to_wb_master.
// master = the bridge itself; slave = the core and Wishbone target facing it.
interface core_to_wb_master_if #(
  parameter int ADDR_W = 32
);
  logic              core_data_req_i;
  logic              core_data_gnt_o;
  logic [ADDR_W-1:0] core_data_addr_i;
  logic [3:0]        core_data_be_i;
  logic              core_data_we_i;
  logic [31:0]       core_data_wdata_i;
  logic              core_data_rvalid_o;
  logic [31:0]       core_data_rdata_o;
  logic              core_data_err_o;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [31:0]       wbm_dat_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;

  modport master (
    input  core_data_req_i, core_data_addr_i, core_data_be_i, core_data_we_i,
           core_data_wdata_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    output core_data_gnt_o, core_data_rvalid_o, core_data_rdata_o, core_data_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output core_data_req_i, core_data_addr_i, core_data_be_i, core_data_we_i,
           core_data_wdata_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  core_data_gnt_o, core_data_rvalid_o, core_data_rdata_o, core_data_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/core_to_wb_master.sv
// Core load/store port to Wishbone classic master bridge, one transaction in flight.
// Optional bus watchdog enabled by defining CORE_WB_TIMEOUT_EN.
module core_to_wb_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  core_to_wb_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;
  logic              timeout;
  logic              done;
  logic              fail;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.core_data_addr_i[1:0];

`ifdef CORE_WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Fires on the TIMEOUT_CYCLES-th BUS cycle, so cyc is high exactly that many cycles.
  assign timeout = (state == BUS) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state != BUS) begin
      tmo_cnt <= '0;
    end else if (!bus.wbm_ack_i && !bus.wbm_err_i) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = bus.wbm_err_i || bus.wbm_ack_i || timeout;
  // Any termination other than a clean ack (err_i, or watchdog) reports an error.
  assign fail = bus.wbm_err_i || !bus.wbm_ack_i;

  assign bus.core_data_gnt_o    = (state == IDLE) && bus.core_data_req_i;
  assign bus.core_data_rvalid_o = rvalid;
  assign bus.core_data_rdata_o  = rdata;
  assign bus.core_data_err_o    = err;
  assign bus.wbm_cyc_o          = cyc;
  assign bus.wbm_stb_o          = stb;
  assign bus.wbm_we_o           = we;
  assign bus.wbm_sel_o          = sel;
  assign bus.wbm_adr_o          = adr;
  assign bus.wbm_dat_o          = dat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cyc    <= 1'b0;
      stb    <= 1'b0;
      we     <= 1'b0;
      sel    <= '0;
      adr    <= '0;
      dat    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.core_data_req_i) begin
            adr   <= {bus.core_data_addr_i[ADDR_W-1:2], 2'b00};
            sel   <= bus.core_data_be_i;
            we    <= bus.core_data_we_i;
            dat   <= bus.core_data_wdata_i;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          if (done) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            rvalid <= 1'b1;
            err    <= fail;
            rdata  <= (fail || we) ? 32'd0 : bus.wbm_dat_i;
            state  <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_to_wb_master.sv
// Directed and randomized bench for core_to_wb_master with a transaction-level reference.
module tb_core_to_wb_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  core_to_wb_master_if #(.ADDR_W(32)) b();

  core_to_wb_master #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction with expectations derived from the bridge's rules.
  task automatic txn(input logic [31:0] a, input logic [3:0] be, input logic w,
                     input logic [31:0] wd, input int waits, input logic [31:0] rd,
                     input logic e, input logic ak);
    logic [31:0] exp_rdata;
    exp_rdata = (e || w) ? 32'd0 : rd;
    b.core_data_req_i   = 1'b1;
    b.core_data_addr_i  = a;
    b.core_data_be_i    = be;
    b.core_data_we_i    = w;
    b.core_data_wdata_i = wd;
    #1;
    chk("gnt_idle", b.core_data_gnt_o, 1);
    tick();
    b.core_data_req_i   = 1'b0;
    b.core_data_addr_i  = $urandom;
    b.core_data_wdata_i = $urandom;
    b.core_data_be_i    = 4'($urandom);
    chk("cyc", b.wbm_cyc_o, 1);
    chk("stb", b.wbm_stb_o, 1);
    chk("we", b.wbm_we_o, w);
    chk("sel", b.wbm_sel_o, be);
    chk("adr", b.wbm_adr_o, a & 32'hFFFF_FFFC);
    chk("dat_o", b.wbm_dat_o, wd);
    chk("rvalid_bus", b.core_data_rvalid_o, 0);
    for (int i = 0; i < waits; i++) begin
      b.core_data_req_i = 1'b1;
      #1;
      chk("gnt_in_bus", b.core_data_gnt_o, 0);
      tick();
      chk("cyc_hold", b.wbm_cyc_o, 1);
      chk("adr_hold", b.wbm_adr_o, a & 32'hFFFF_FFFC);
      chk("dat_hold", b.wbm_dat_o, wd);
      chk("rvalid_wait", b.core_data_rvalid_o, 0);
    end
    b.core_data_req_i = 1'b0;
    b.wbm_dat_i = rd;
    b.wbm_ack_i = ak;
    b.wbm_err_i = e;
    tick();
    b.wbm_ack_i = 1'b0;
    b.wbm_err_i = 1'b0;
    b.wbm_dat_i = $urandom;
    chk("rvalid", b.core_data_rvalid_o, 1);
    chk("err", b.core_data_err_o, e);
    chk("rdata", b.core_data_rdata_o, exp_rdata);
    chk("cyc_drop", b.wbm_cyc_o, 0);
    chk("stb_drop", b.wbm_stb_o, 0);
    b.core_data_req_i = 1'b1;
    #1;
    chk("gnt_in_resp", b.core_data_gnt_o, 0);
    b.core_data_req_i = 1'b0;
    tick();
    chk("rvalid_one_cycle", b.core_data_rvalid_o, 0);
    chk("rdata_held", b.core_data_rdata_o, exp_rdata);
  endtask

  task automatic start_read(input logic [31:0] a);
    b.core_data_req_i  = 1'b1;
    b.core_data_addr_i = a;
    b.core_data_be_i   = 4'hF;
    b.core_data_we_i   = 1'b0;
    tick();
    b.core_data_req_i  = 1'b0;
  endtask

  initial begin
    int gnt_at[$];
    int cnt;
    b.core_data_req_i   = 1'b0;
    b.core_data_addr_i  = '0;
    b.core_data_be_i    = '0;
    b.core_data_we_i    = 1'b0;
    b.core_data_wdata_i = '0;
    b.wbm_dat_i         = '0;
    b.wbm_ack_i         = 1'b0;
    b.wbm_err_i         = 1'b0;

    // Reset values
    #12;
    chk("rst_cyc", b.wbm_cyc_o, 0);
    chk("rst_stb", b.wbm_stb_o, 0);
    chk("rst_rvalid", b.core_data_rvalid_o, 0);
    chk("rst_rdata", b.core_data_rdata_o, 0);
    chk("rst_adr", b.wbm_adr_o, 0);
    chk("rst_sel", b.wbm_sel_o, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // ack/err while idle are ignored
    b.wbm_ack_i = 1'b1;
    b.wbm_err_i = 1'b1;
    tick();
    b.wbm_ack_i = 1'b0;
    b.wbm_err_i = 1'b0;
    chk("idle_ack_rvalid", b.core_data_rvalid_o, 0);
    chk("idle_ack_cyc", b.wbm_cyc_o, 0);

    // Directed: zero-wait write, 3-wait read, err+ack read, be=0
    txn(32'h3000_0104, 4'hF, 1'b1, 32'hA5A5_1234, 0, 32'h1111_2222, 1'b0, 1'b1);
    txn(32'h3000_0203, 4'hF, 1'b0, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b1);
    txn(32'h3000_0300, 4'hF, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    txn(32'h0000_0012, 4'h0, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b1);

    // Back-to-back with req held high and zero-wait acks
    b.core_data_req_i   = 1'b1;
    b.core_data_addr_i  = 32'h4000_0000;
    b.core_data_we_i    = 1'b1;
    b.core_data_be_i    = 4'hF;
    b.core_data_wdata_i = 32'h0BAD_F00D;
    for (int i = 0; i < 9; i++) begin
      b.wbm_ack_i = b.wbm_cyc_o;
      #1;
      if (b.core_data_gnt_o === 1'b1) gnt_at.push_back(i);
      chk("b2b_gnt_excl", b.core_data_gnt_o && (b.wbm_cyc_o || b.core_data_rvalid_o), 0);
      tick();
    end
    b.core_data_req_i = 1'b0;
    b.wbm_ack_i = 1'b0;
    chk("b2b_gnt_count", gnt_at.size(), 3);
    if (gnt_at.size() >= 3) begin
      chk("b2b_interval1", gnt_at[1] - gnt_at[0], 3);
      chk("b2b_interval2", gnt_at[2] - gnt_at[1], 3);
    end
    tick();
    tick();

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      logic e;
      logic ak;
      e  = ($urandom_range(0, 4) == 0);
      ak = e ? 1'($urandom_range(0, 1)) : 1'b1;
      txn($urandom, 4'($urandom), 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 3), $urandom, e, ak);
    end

`ifdef CORE_WB_TIMEOUT_EN
    start_read(32'h5000_0000);
    cnt = 0;
    while (b.wbm_cyc_o === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("tmo_bus_cycles", cnt, 8);
    chk("tmo_rvalid", b.core_data_rvalid_o, 1);
    chk("tmo_err", b.core_data_err_o, 1);
    chk("tmo_rdata", b.core_data_rdata_o, 0);
    tick();
    chk("tmo_rvalid_drop", b.core_data_rvalid_o, 0);
`else
    start_read(32'h5000_0000);
    cnt = 0;
    repeat (1000) begin
      tick();
      cnt++;
    end
    chk("notmo_cyc", b.wbm_cyc_o, 1);
    chk("notmo_rvalid", b.core_data_rvalid_o, 0);
    b.wbm_dat_i = 32'h1234_5678;
    b.wbm_ack_i = 1'b1;
    tick();
    b.wbm_ack_i = 1'b0;
    chk("notmo_late_rvalid", b.core_data_rvalid_o, 1);
    chk("notmo_late_rdata", b.core_data_rdata_o, 32'h1234_5678);
    tick();
`endif

    // Reset in the middle of a bus cycle
    start_read(32'h6000_0008);
    chk("mid_cyc_before", b.wbm_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", b.wbm_cyc_o, 0);
    chk("mid_rst_stb", b.wbm_stb_o, 0);
    chk("mid_rst_rvalid", b.core_data_rvalid_o, 0);
    chk("mid_rst_adr", b.wbm_adr_o, 0);
    tick();
    rst_n = 1'b1;
    b.wbm_ack_i = 1'b1;
    b.wbm_dat_i = 32'hFFFF_0000;
    tick();
    b.wbm_ack_i = 1'b0;
    chk("late_ack_rvalid", b.core_data_rvalid_o, 0);
    chk("late_ack_cyc", b.wbm_cyc_o, 0);
    tick();
    chk("late_ack_rvalid2", b.core_data_rvalid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
